// File: rtl/cva6v_rvfi_commit_buffer.sv
// Retirement-record FIFO between the CVA6V commit ports and the trace drain.
// Captures up to NR_PORTS records per cycle, tags them with a sequence number, drops on overflow.
module cva6v_rvfi_commit_buffer #(
    parameter int NR_PORTS = 2,
    parameter int REC_W    = 128,
    parameter int DEPTH    = 16,
    parameter int SEQ_W    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [NR_PORTS-1:0]       commit_valid_i,
    input  logic [NR_PORTS*REC_W-1:0] commit_data_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [REC_W-1:0]          m_data_o,
    output logic [SEQ_W-1:0]          m_seq_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      overflow_o,
    output logic [31:0]               drop_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [REC_W-1:0] data_mem_q [DEPTH];
    logic [SEQ_W-1:0] seq_mem_q  [DEPTH];

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      drop_q, drop_d;
    logic [REC_W-1:0] out_data_q, out_data_d;
    logic [SEQ_W-1:0] out_seq_q, out_seq_d;

    logic [NR_PORTS-1:0] we;
    logic [PW-1:0]       waddr [NR_PORTS];
    logic [SEQ_W-1:0]    wseq  [NR_PORTS];
    logic [LW-1:0]       free, nwr, ndrop;
    logic                pop;
    logic [32:0]         drop_sum;

    always_comb begin
        free  = LW'(DEPTH) - level_q;
        nwr   = '0;
        ndrop = '0;
        // Valid ports are compacted in port order; only the first `free` of them fit.
        for (int k = 0; k < NR_PORTS; k++) begin
            we[k]    = 1'b0;
            waddr[k] = wr_ptr_q + PW'(nwr);
            wseq[k]  = seq_q + SEQ_W'(nwr);
            if (enable_i && commit_valid_i[k]) begin
                if (nwr < free) begin
                    we[k] = 1'b1;
                    nwr   = nwr + 1'b1;
                end else begin
                    ndrop = ndrop + 1'b1;
                end
            end
        end

        pop        = (level_q != '0) && m_ready_i;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + nwr[PW-1:0];
        level_d    = level_q + nwr - LW'(pop);
        seq_d      = seq_q + SEQ_W'(nwr);
        drop_sum   = {1'b0, drop_q} + 33'(ndrop);
        drop_d     = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        overflow_d = overflow_q | (ndrop != '0);

        // Output registers track the next head entry, bypassing a same-cycle write into an empty FIFO.
        out_data_d = out_data_q;
        out_seq_d  = out_seq_q;
        if (level_d != '0) begin
            out_data_d = data_mem_q[rd_ptr_d];
            out_seq_d  = seq_mem_q[rd_ptr_d];
            for (int k = 0; k < NR_PORTS; k++) begin
                if (we[k] && (waddr[k] == rd_ptr_d)) begin
                    out_data_d = commit_data_i[k*REC_W +: REC_W];
                    out_seq_d  = wseq[k];
                end
            end
        end

        if (clear_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            seq_d      = '0;
            drop_d     = '0;
            overflow_d = 1'b0;
            out_data_d = '0;
            out_seq_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            out_data_q <= '0;
            out_seq_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            out_data_q <= out_data_d;
            out_seq_q  <= out_seq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_PORTS; k++) begin
            if (we[k] && !clear_i) begin
                data_mem_q[waddr[k]] <= commit_data_i[k*REC_W +: REC_W];
                seq_mem_q[waddr[k]]  <= wseq[k];
            end
        end
    end

    assign m_valid_o  = (level_q != '0);
    assign m_data_o   = out_data_q;
    assign m_seq_o    = out_seq_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cva6v_rvfi_commit_buffer.sv
// Bench for cva6v_rvfi_commit_buffer: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based model of the buffer.
module tb_cva6v_rvfi_commit_buffer;
  localparam int NR_PORTS = 2;
  localparam int REC_W    = 128;
  localparam int DEPTH    = 16;
  localparam int SEQ_W    = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      enable_i = 1'b0;
  logic                      clear_i = 1'b0;
  logic [NR_PORTS-1:0]       commit_valid_i = '0;
  logic [NR_PORTS*REC_W-1:0] commit_data_i = '0;
  logic                      m_ready_i = 1'b0;
  logic                      m_valid_o;
  logic [REC_W-1:0]          m_data_o;
  logic [SEQ_W-1:0]          m_seq_o;
  logic [$clog2(DEPTH):0]    level_o;
  logic                      overflow_o;
  logic [31:0]               drop_cnt_o;

  cva6v_rvfi_commit_buffer #(
    .NR_PORTS(NR_PORTS), .REC_W(REC_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .clear_i(clear_i),
    .commit_valid_i(commit_valid_i), .commit_data_i(commit_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_seq_o(m_seq_o), .level_o(level_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard / reference model: {seq, data} per buffered record
  logic [SEQ_W+REC_W-1:0] exp_q[$];
  logic [REC_W-1:0]       m_last_data;
  logic [SEQ_W-1:0]       m_last_seq;
  logic [SEQ_W-1:0]       m_next_seq;
  longint                 m_drops;
  bit                     m_ovf;

  task automatic model_flush();
    exp_q.delete();
    m_last_data = '0;
    m_last_seq  = '0;
    m_next_seq  = '0;
    m_drops     = 0;
    m_ovf       = 0;
  endtask

  task automatic model_step();
    int free;
    int nw;
    if (clear_i) begin
      model_flush();
      return;
    end
    free = DEPTH - exp_q.size();
    nw   = 0;
    if (exp_q.size() != 0 && m_ready_i) void'(exp_q.pop_front());
    for (int k = 0; k < NR_PORTS; k++) begin
      if (enable_i && commit_valid_i[k]) begin
        if (nw < free) begin
          exp_q.push_back({m_next_seq, commit_data_i[k*REC_W +: REC_W]});
          m_next_seq = m_next_seq + 1'b1;
          nw++;
        end else begin
          m_drops++;
          m_ovf = 1;
        end
      end
    end
    if (exp_q.size() != 0) {m_last_seq, m_last_data} = exp_q[0];
  endtask

  task automatic check_outputs();
    logic [31:0] exp_drop;
    exp_drop = (m_drops > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_drops[31:0];
    check_eq("valid", REC_W'(m_valid_o), REC_W'(exp_q.size() != 0));
    check_eq("level", REC_W'(level_o), REC_W'(exp_q.size()));
    check_eq("data", m_data_o, m_last_data);
    check_eq("seq", REC_W'(m_seq_o), REC_W'(m_last_seq));
    check_eq("overflow", REC_W'(overflow_o), REC_W'(m_ovf));
    check_eq("drop_cnt", REC_W'(drop_cnt_o), REC_W'(exp_drop));
  endtask

  // driver tasks: one call = one clock cycle of stimulus
  task automatic drive(input bit en, input bit clr, input logic [NR_PORTS-1:0] vld, input bit rdy);
    @(negedge clk);
    check_outputs();
    enable_i       = en;
    clear_i        = clr;
    commit_valid_i = vld;
    m_ready_i      = rdy;
    for (int k = 0; k < NR_PORTS; k++)
      commit_data_i[k*REC_W +: REC_W] = {$urandom, $urandom, $urandom, $urandom};
    model_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    enable_i       = 1'b0;
    clear_i        = 1'b0;
    commit_valid_i = '0;
    m_ready_i      = 1'b0;
    model_flush();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    model_flush();

    // reset state, then a single commit on port 0
    do_reset();
    drive(1, 0, 2'b01, 0);
    #1;
    check_eq("t1_valid", REC_W'(m_valid_o), 1);
    check_eq("t1_seq", REC_W'(m_seq_o), 0);
    check_eq("t1_level", REC_W'(level_o), 1);

    // dual commit drained back to back
    do_reset();
    drive(1, 0, 2'b11, 1);
    #1;
    check_eq("t2_seq_a", REC_W'(m_seq_o), 0);
    check_eq("t2_level_a", REC_W'(level_o), 2);
    drive(1, 0, 2'b00, 1);
    #1;
    check_eq("t2_seq_b", REC_W'(m_seq_o), 1);
    drive(1, 0, 2'b00, 1);
    #1;
    check_eq("t2_empty", REC_W'(m_valid_o), 0);
    check_eq("t2_hold_seq", REC_W'(m_seq_o), 1);

    // fill to full with overflow
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, 0, 2'b11, 0);
    #1;
    check_eq("t3_level", REC_W'(level_o), 16);
    check_eq("t3_drop", REC_W'(drop_cnt_o), 2);
    check_eq("t3_ovf", REC_W'(overflow_o), 1);
    check_eq("t3_head_seq", REC_W'(m_seq_o), 0);

    // pop frees one slot; the pop in the same cycle adds no space
    drive(1, 0, 2'b00, 1);
    drive(1, 0, 2'b11, 1);
    #1;
    check_eq("t4_level", REC_W'(level_o), 15);
    check_eq("t4_drop", REC_W'(drop_cnt_o), 3);
    check_eq("t4_head_seq", REC_W'(m_seq_o), 2);

    // enable low ignores commits; drain to five entries, then clear
    for (int i = 0; i < 10; i++) drive(0, 0, 2'b11, 1);
    #1;
    check_eq("t6_level_pre", REC_W'(level_o), 5);
    check_eq("t6_drop_pre", REC_W'(drop_cnt_o), 3);
    drive(1, 1, 2'b11, 1);
    #1;
    check_eq("t6_level", REC_W'(level_o), 0);
    check_eq("t6_valid", REC_W'(m_valid_o), 0);
    check_eq("t6_ovf", REC_W'(overflow_o), 0);
    check_eq("t6_drop", REC_W'(drop_cnt_o), 0);
    drive(1, 0, 2'b01, 0);
    #1;
    check_eq("t6_next_tag", REC_W'(m_seq_o), 0);

    // randomized traffic with varying drain pressure, clears and async resets
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          drive($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
                NR_PORTS'($urandom_range(0, 3)), $urandom_range(1, 100) <= rdy_pct);
        end
      end
    end

    // sequence tag wraps after 2^SEQ_W records
    drive(0, 1, 2'b00, 1);
    for (int i = 0; i < (1 << SEQ_W) + 1; i++) drive(1, 0, 2'b01, 1);
    #1;
    check_eq("t5_last_tag", REC_W'(m_seq_o), 0);
    check_eq("t5_drop", REC_W'(drop_cnt_o), 0);
    drive(1, 0, 2'b00, 1);
    drive(1, 0, 2'b00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
